// File: rtl/io_bus_pkg.sv
// Shared types and constants for the tiny32 I/O bus controller.
package io_bus_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } io_state_e;

  // Slot numbers as decoded from the top address bits.
  localparam int SLOT_PORT    = 0;
  localparam int SLOT_UART    = 1;
  localparam int SLOT_SPI_LCD = 2;
  localparam int SLOT_TIMER   = 3;
  localparam int SLOT_PROBE   = 4;
  localparam int SLOT_DAC1    = 5;
  localparam int SLOT_DAC2    = 6;

  // Port and both DACs complete without waiting for an acknowledge.
  localparam logic [7:0]  DEFAULT_IMMEDIATE_MASK = 8'b0110_0001;

  // Read data handed back when a peripheral never answers.
  localparam logic [31:0] DEFAULT_ERROR_DATA     = 32'hFFFF_FFFF;

endpackage

// File: rtl/io_bus_ctrl_if.sv
// CPU-side and peripheral-side signals of the I/O bus controller.
// slave  : the controller's view.
// master : the environment's view (CPU plus peripherals).
interface io_bus_ctrl_if #(
  parameter int SELECTOR_BITS = 3
);
  localparam int SLOTS = 2 ** SELECTOR_BITS;

  logic                  io_req;
  logic                  io_nwr;
  logic [31:0]           io_address;
  logic [31:0]           io_data_out;
  logic                  io_ready;
  logic [SLOTS-1:0]      dev_req;
  logic                  dev_nwr;
  logic [SLOTS-1:0]      dev_ack;
  logic [32*SLOTS-1:0]   dev_rdata;
  logic                  bus_error;
  logic [31:0]           err_address;
  logic                  err_clear;

  modport slave (
    input  io_req, io_nwr, io_address, dev_ack, dev_rdata, err_clear,
    output io_data_out, io_ready, dev_req, dev_nwr, bus_error, err_address
  );

  modport master (
    output io_req, io_nwr, io_address, dev_ack, dev_rdata, err_clear,
    input  io_data_out, io_ready, dev_req, dev_nwr, bus_error, err_address
  );

endinterface

// File: rtl/io_bus_ctrl_timeout_counter.sv
// Saturating wait counter; expired flags the last permitted cycle of a wait.
module io_timeout_counter #(
  parameter int BITS  = 8,
  parameter int LIMIT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [BITS-1:0] LAST  = BITS'(LIMIT - 1);
  localparam logic [BITS-1:0] MAX_V = '1;

  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] cnt_d;

  // Clear has priority; counting stops at the all-ones value instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/io_bus_ctrl.sv
// tiny32 I/O bus sequencing controller: slot decode, one-at-a-time peripheral
// requests, read-data return and timeout with a sticky error record.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int                              SELECTOR_BITS  = 3,
  parameter logic [(2**SELECTOR_BITS)-1:0]   IMMEDIATE_MASK = DEFAULT_IMMEDIATE_MASK,
  parameter int                              TIMEOUT_BITS   = 8,
  parameter int                              TIMEOUT_CYCLES = 200,
  parameter logic [31:0]                     ERROR_DATA     = DEFAULT_ERROR_DATA
) (
  input  logic         clk,
  input  logic         reset,
  io_bus_ctrl_if.slave bus
);

  localparam int SLOTS = 2 ** SELECTOR_BITS;

  io_state_e                state_q,     state_d;
  logic [SELECTOR_BITS-1:0] slot_q,      slot_d;
  logic                     dev_nwr_q,   dev_nwr_d;
  logic [31:0]              addr_q,      addr_d;
  logic [SLOTS-1:0]         dev_req_q,   dev_req_d;
  logic                     io_ready_q,  io_ready_d;
  logic [31:0]              data_q,      data_d;
  logic                     bus_error_q, bus_error_d;
  logic [31:0]              err_addr_q,  err_addr_d;

  logic                     cnt_clear;
  logic                     cnt_enable;
  logic                     cnt_expired;
  logic                     timeout;

  logic [SELECTOR_BITS-1:0] req_slot;
  logic [31:0]              rdata_word [SLOTS];
  logic                     ack_sel;
  logic [31:0]              rdata_sel;

  assign req_slot = bus.io_address[31 -: SELECTOR_BITS];

  // Unflatten the peripheral read-data bus into one word per slot.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_rdata
    assign rdata_word[gi] = bus.dev_rdata[32*gi +: 32];
  end

  // Only the latched slot's acknowledge and data are ever looked at.
  assign ack_sel   = bus.dev_ack[slot_q];
  assign rdata_sel = rdata_word[slot_q];

  io_timeout_counter #(
    .BITS  (TIMEOUT_BITS),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // Next-state logic for the sequencer, data return and error record.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    dev_nwr_d   = dev_nwr_q;
    addr_d      = addr_q;
    dev_req_d   = dev_req_q;
    io_ready_d  = io_ready_q;
    data_d      = data_q;
    bus_error_d = bus_error_q;
    err_addr_d  = err_addr_q;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;
    timeout     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.io_req) begin
          slot_d              = req_slot;
          dev_nwr_d           = bus.io_nwr;
          addr_d              = bus.io_address;
          dev_req_d           = '0;
          dev_req_d[req_slot] = 1'b1;
          io_ready_d          = 1'b0;
          cnt_clear           = 1'b1;
          state_d             = IMMEDIATE_MASK[req_slot] ? ST_DONE : ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        cnt_enable = 1'b1;
        if (ack_sel) begin
          data_d     = dev_nwr_q ? rdata_sel : 32'h0;
          dev_req_d  = '0;
          io_ready_d = 1'b1;
          state_d    = ST_DONE;
        end else if (cnt_expired) begin
          timeout    = 1'b1;
          data_d     = ERROR_DATA;
          dev_req_d  = '0;
          io_ready_d = 1'b1;
          state_d    = ST_DONE;
        end else if (!bus.io_req) begin
          // CPU gave up: abandon quietly, nothing is recorded.
          dev_req_d = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (!io_ready_q) begin
          // Immediate slot: the single request cycle has just been issued.
          data_d     = dev_nwr_q ? rdata_sel : 32'h0;
          dev_req_d  = '0;
          io_ready_d = 1'b1;
        end else if (!bus.io_req) begin
          io_ready_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        dev_req_d  = '0;
        io_ready_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    // A timeout in the same cycle as a clear wins and refreshes the address.
    if (bus.err_clear) begin
      bus_error_d = 1'b0;
    end
    if (timeout) begin
      bus_error_d = 1'b1;
      if (!bus_error_q || bus.err_clear) begin
        err_addr_d = addr_q;
      end
    end
  end

  // All controller state and outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      dev_nwr_q   <= 1'b0;
      addr_q      <= '0;
      dev_req_q   <= '0;
      io_ready_q  <= 1'b0;
      data_q      <= '0;
      bus_error_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      dev_nwr_q   <= dev_nwr_d;
      addr_q      <= addr_d;
      dev_req_q   <= dev_req_d;
      io_ready_q  <= io_ready_d;
      data_q      <= data_d;
      bus_error_q <= bus_error_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.io_data_out = data_q;
  assign bus.io_ready    = io_ready_q;
  assign bus.dev_req     = dev_req_q;
  assign bus.dev_nwr     = dev_nwr_q;
  assign bus.bus_error   = bus_error_q;
  assign bus.err_address = err_addr_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Randomized self-checking bench for io_bus_ctrl against a transaction-level model.
module tb_io_bus_ctrl;

  localparam int          TC    = 200;
  localparam int          SLOTS = 8;
  localparam logic [31:0] ERR_W = 32'hFFFF_FFFF;

  // Transaction kinds for the model.
  localparam int M_ACK     = 0;
  localparam int M_TIMEOUT = 1;
  localparam int M_ABORT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_bus_ctrl_if #(.SELECTOR_BITS(3)) bus ();

  io_bus_ctrl #(
    .SELECTOR_BITS  (3),
    .IMMEDIATE_MASK (8'b0110_0001),
    .TIMEOUT_BITS   (8),
    .TIMEOUT_CYCLES (TC),
    .ERROR_DATA     (ERR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn    = 0;
  logic [7:0]  imm_mask = 8'b0110_0001;
  bit          m_err    = 1'b0;
  logic [31:0] m_addr   = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Random acknowledges on every slot except the one being served.
  function automatic logic [7:0] noise(input logic [7:0] sel_oh);
    return 8'($urandom) & ~sel_oh;
  endfunction

  // One CPU access; the expected outcome comes from the bus rules, not the RTL.
  task automatic run_txn(input logic [31:0] addr, input bit nwr, input int mode,
                         input int d, input int a, input bit clr_to);
    int           slot;
    logic [7:0]   oh;
    bit           imm;
    int           eff;
    int           exp_ready;
    logic [31:0]  exp_data;
    logic [31:0]  words [SLOTS];
    logic [255:0] rd;
    int           ready_k;
    int           req_cycles;
    int           req_bad;

    slot = int'(addr[31:29]);
    oh   = 8'b1 << slot;
    imm  = imm_mask[slot];
    eff  = imm ? M_ACK : mode;
    for (int i = 0; i < SLOTS; i++) begin
      words[i]       = $urandom;
      rd[32*i +: 32] = words[i];
    end

    // Model: immediate slots finish one edge after acceptance; waited slots at
    // the ack edge or after TC edges; aborts never complete.
    if (imm) begin
      exp_ready = 1;
      exp_data  = nwr ? words[slot] : 32'h0;
    end else if (eff == M_ACK) begin
      exp_ready = d;
      exp_data  = nwr ? words[slot] : 32'h0;
    end else if (eff == M_TIMEOUT) begin
      exp_ready = TC;
      exp_data  = ERR_W;
    end else begin
      exp_ready = -1;
      exp_data  = 32'h0;
    end

    @(negedge clk);
    bus.io_address = addr;
    bus.io_nwr     = nwr;
    bus.io_req     = 1'b1;
    bus.dev_rdata  = rd;
    bus.dev_ack    = noise(oh);
    bus.err_clear  = 1'b0;

    ready_k    = -1;
    req_cycles = 0;
    req_bad    = 0;
    for (int k = 0; k <= TC + 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.io_ready && ready_k < 0) ready_k = k;
      if (bus.dev_req != 8'h0) begin
        req_cycles++;
        if (bus.dev_req != oh) req_bad++;
      end
      if (k == 0) check_eq("dev_nwr", 32'(bus.dev_nwr), 32'(nwr));
      bus.dev_ack = noise(oh) | ((eff == M_ACK && !imm && k + 1 == d) ? oh : 8'h0);
      bus.err_clear = (eff == M_TIMEOUT && clr_to && k + 1 == TC);
      if (eff == M_ABORT && k + 1 == a) bus.io_req = 1'b0;
      if (ready_k >= 0) break;
      if (eff == M_ABORT && k >= a + 3) break;
    end

    check_eq("latency", 32'(ready_k), 32'(exp_ready));
    check_eq("dev_req_cycles", 32'(req_cycles), 32'((eff == M_ABORT) ? a : exp_ready));
    check_eq("dev_req_onehot", 32'(req_bad), 32'd0);
    if (exp_ready >= 0) check_eq("io_data_out", bus.io_data_out, exp_data);

    if (eff == M_TIMEOUT) begin
      if (!m_err || clr_to) m_addr = addr;
      m_err = 1'b1;
    end
    check_eq("bus_error", 32'(bus.bus_error), 32'(m_err));
    check_eq("err_address", bus.err_address, m_addr);

    // Release the request and confirm the return to idle.
    bus.io_req    = 1'b0;
    bus.err_clear = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("ready_release", 32'(bus.io_ready), 32'd0);
    check_eq("req_release", 32'(bus.dev_req), 32'd0);

    n_txn++;
    $display("txn %0d addr=%h nwr=%0b mode=%0d lat=%0d data=%h bus_error=%0b",
             n_txn, addr, nwr, eff, ready_k, bus.io_data_out, bus.bus_error);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.err_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.err_clear = 1'b0;
    m_err = 1'b0;
    check_eq("clear_bus_error", 32'(bus.bus_error), 32'd0);
    check_eq("clear_err_address", bus.err_address, m_addr);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_io_ready"}, 32'(bus.io_ready), 32'd0);
    check_eq({tag, "_dev_req"}, 32'(bus.dev_req), 32'd0);
    check_eq({tag, "_dev_nwr"}, 32'(bus.dev_nwr), 32'd0);
    check_eq({tag, "_bus_error"}, 32'(bus.bus_error), 32'd0);
    check_eq({tag, "_io_data_out"}, bus.io_data_out, 32'd0);
    check_eq({tag, "_err_address"}, bus.err_address, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          nwr;
    int          r;
    int          mode;
    int          d;
    int          a;
    bit          clr;
    logic [31:0] addr;

    reset          = 1'b1;
    bus.io_req     = 1'b0;
    bus.io_nwr     = 1'b0;
    bus.io_address = 32'h0;
    bus.dev_ack    = 8'h0;
    bus.dev_rdata  = '0;
    bus.err_clear  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Directed cases from the bus behaviour description.
    run_txn(32'h8000_0000, 1'b1, M_ACK, 5, 0, 1'b0);       // probe read, ack after 5
    run_txn(32'hA000_0000, 1'b0, M_ACK, 1, 0, 1'b0);       // DAC1 write, immediate
    run_txn(32'h6000_0000, 1'b1, M_TIMEOUT, 0, 0, 1'b0);   // timer read, hung
    run_txn(32'h2000_0000, 1'b1, M_TIMEOUT, 0, 0, 1'b0);   // second timeout keeps address
    run_txn(32'h4000_0010, 1'b1, M_TIMEOUT, 0, 0, 1'b1);   // clear coincides with timeout
    do_clear();
    run_txn(32'h4000_0000, 1'b1, M_ABORT, 10, 3, 1'b0);    // CPU abort at cycle 3
    run_txn(32'h4000_0004, 1'b1, M_ACK, 6, 0, 1'b0);       // SPI read amid foreign acks

    // Reset asserted while an access is outstanding.
    @(negedge clk);
    bus.io_address = 32'h2000_0000;
    bus.io_nwr     = 1'b1;
    bus.io_req     = 1'b1;
    bus.dev_ack    = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("pre_reset_dev_req", 32'(bus.dev_req), 32'h02);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    m_err  = 1'b0;
    m_addr = 32'h0;
    bus.io_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_txn(32'h2000_0100, 1'b1, M_ACK, 4, 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      addr = $urandom;
      nwr  = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      mode = (r == 0) ? M_TIMEOUT : ((r < 3) ? M_ABORT : M_ACK);
      d    = $urandom_range(2, 12);
      a    = $urandom_range(1, d - 1);
      clr  = (mode == M_TIMEOUT) && ($urandom_range(0, 1) == 1);
      run_txn(addr, nwr, mode, d, a, clr);
      if ($urandom_range(0, 4) == 0) do_clear();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
